// File: rtl/mdr_pkg.sv
// Shared types and defaults for the MDR datapath blocks.
// Holds the unload FSM state type and the default word length.
package mdr_pkg;

    localparam int WORD_LENGTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_RES = 3'd1,
        SHOW_REM = 3'd2,
        SHOW_ERR = 3'd3,
        RELEASE  = 3'd4
    } unload_state_e;

endpackage

// File: rtl/Register.sv
// Enable-gated storage register with synchronous active-high reset.
// Reset has priority over the load enable.
module Register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/unload_timer.sv
// Dwell timer for the display states: counts enabled cycles since the last clear.
// timeout is high during the TIMEOUT-th enabled cycle; TIMEOUT=0 never fires.
module unload_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    // Counter width is at least 1 bit; with TIMEOUT=0 the count is unused.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (TIMEOUT != 0) && enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/result_unload.sv
// Presents an MDR core result to the user: result, then remainder (or error),
// advanced by Next or a dwell timeout, then a one-cycle Ready back to the loader.
module result_unload
    import mdr_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Done,
    input  logic [WORD_LENGTH-1:0] Result,
    input  logic [WORD_LENGTH-1:0] Remainder,
    input  logic                   Error,
    input  logic                   Next,
    output logic [WORD_LENGTH-1:0] DataOut,
    output logic                   ShowResult,
    output logic                   ShowRemainder,
    output logic                   ErrorFlag,
    output logic                   Busy,
    output logic                   Ready,
    output unload_state_e          dbg_state
);

    unload_state_e          state;
    unload_state_e          state_next;
    logic [WORD_LENGTH-1:0] res_q;
    logic [WORD_LENGTH-1:0] rem_q;
    logic                   showing;
    logic                   advance;
    logic                   timeout;
    logic                   timer_clear;

    Register #(.WIDTH(WORD_LENGTH)) u_res_reg (
        .clk   (clk),
        .reset (reset),
        .en    (Done),
        .d     (Result),
        .q     (res_q)
    );

    Register #(.WIDTH(WORD_LENGTH)) u_rem_reg (
        .clk   (clk),
        .reset (reset),
        .en    (Done),
        .d     (Remainder),
        .q     (rem_q)
    );

    // Any state entry restarts the dwell count, including a superseding Done.
    assign timer_clear = reset || Done || advance;

    unload_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clear   (timer_clear),
        .enable  (showing),
        .timeout (timeout)
    );

    assign showing = (state == SHOW_RES) || (state == SHOW_REM) || (state == SHOW_ERR);
    assign advance = showing && (Next || timeout);

    always_comb begin
        state_next = state;
        if (Done) begin
            state_next = Error ? SHOW_ERR : SHOW_RES;
        end else begin
            case (state)
                SHOW_RES: if (advance) state_next = SHOW_REM;
                SHOW_REM: if (advance) state_next = RELEASE;
                SHOW_ERR: if (advance) state_next = RELEASE;
                RELEASE:  state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Flags are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ShowResult    <= 1'b0;
            ShowRemainder <= 1'b0;
            ErrorFlag     <= 1'b0;
            Busy          <= 1'b0;
            Ready         <= 1'b0;
        end else begin
            state         <= state_next;
            ShowResult    <= (state_next == SHOW_RES);
            ShowRemainder <= (state_next == SHOW_REM);
            ErrorFlag     <= (state_next == SHOW_ERR);
            Busy          <= (state_next == SHOW_RES) || (state_next == SHOW_REM) ||
                             (state_next == SHOW_ERR);
            Ready         <= (state_next == RELEASE);
        end
    end

    always_comb begin
        DataOut = '0;
        if (state == SHOW_RES) begin
            DataOut = res_q;
        end else if (state == SHOW_REM) begin
            DataOut = rem_q;
        end
    end

    assign dbg_state = state;

endmodule
